// File: rtl/inst_mem_pkg.sv
// Shared widths, fetch-enable levels and loader FSM encoding for the instruction memory.
package inst_mem_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned ADDR_BUS_W = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned PART_W     = INST_W - BYTE_W;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    INST_MEM_IDLE  = 2'd0,
    INST_MEM_LOAD  = 2'd1,
    INST_MEM_FLUSH = 2'd2
  } inst_mem_state_e;

  typedef struct packed {
    logic              we;
    logic [INST_W-1:0] data;
  } mem_wr_t;

endpackage

// File: rtl/inst_mem.sv
// Instruction memory with a byte-stream program loader; zero-latency fetch port gated
// to NOP while loading, in reset or when the fetch port is disabled.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_BUS_W-1:0] addr,
  output logic [INST_W-1:0]     inst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [BYTE_W-1:0]     ld_data,
  output logic                  ld_ready,
  input  logic                  ld_done,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   word_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  inst_mem_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [PART_W-1:0]       part_q, part_d;
  logic [CNT_W-1:0]        word_cnt_d;
  mem_wr_t                 wr;

  logic [INST_W-1:0]       mem [DEPTH];

  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_BUS_W-1:ADDR_WIDTH+2], addr[1:0]};

  // Next-state, byte packing and word-write decode
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    byte_cnt_d = byte_cnt_q;
    part_d     = part_q;
    word_cnt_d = word_cnt;
    wr         = '0;

    if (ld_start) begin
      state_d    = INST_MEM_LOAD;
      wptr_d     = '0;
      byte_cnt_d = 2'd0;
      part_d     = '0;
      word_cnt_d = '0;
    end else begin
      unique case (state_q)
        INST_MEM_LOAD: begin
          if (ld_valid) begin
            if (byte_cnt_q == 2'd3) begin
              wr.we      = 1'b1;
              wr.data    = {part_q, ld_data};
              wptr_d     = wptr_q + ADDR_WIDTH'(1);
              word_cnt_d = (word_cnt == CNT_MAX) ? word_cnt : word_cnt + CNT_W'(1);
              byte_cnt_d = 2'd0;
              part_d     = '0;
            end else begin
              unique case (byte_cnt_q)
                2'd0:    part_d[23:16] = ld_data;
                2'd1:    part_d[15:8]  = ld_data;
                default: part_d[7:0]   = ld_data;
              endcase
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
          // ld_done sees the byte count after this cycle's byte is taken
          if (ld_done) begin
            state_d = (byte_cnt_d == 2'd0) ? INST_MEM_IDLE : INST_MEM_FLUSH;
          end
        end
        INST_MEM_FLUSH: begin
          wr.we      = 1'b1;
          wr.data    = {part_q, BYTE_W'(0)};
          wptr_d     = wptr_q + ADDR_WIDTH'(1);
          word_cnt_d = (word_cnt == CNT_MAX) ? word_cnt : word_cnt + CNT_W'(1);
          byte_cnt_d = 2'd0;
          part_d     = '0;
          state_d    = INST_MEM_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INST_MEM_IDLE;
      wptr_q     <= '0;
      byte_cnt_q <= 2'd0;
      part_q     <= '0;
      word_cnt   <= '0;
      busy       <= 1'b0;
      ld_ready   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      byte_cnt_q <= byte_cnt_d;
      part_q     <= part_d;
      word_cnt   <= word_cnt_d;
      busy       <= (state_d != INST_MEM_IDLE);
      ld_ready   <= (state_d == INST_MEM_LOAD);
    end
  end

  // Array is never reset so a reset mid-load keeps previously written words
  always_ff @(posedge clk) begin
    if (wr.we && !rst) begin
      mem[wptr_q] <= wr.data;
    end
  end

  assign inst = (ce == CHIP_DISABLE || busy || rst) ? '0 : mem[addr[ADDR_WIDTH+1:2]];

endmodule

// File: tb/tb_inst_mem.sv
// Randomised and directed bench for inst_mem; two instances (ADDR_WIDTH 10 and 2)
// share one stimulus stream and are compared against a queue-based load model.
module tb_inst_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_done = 1'b0;

  logic [31:0] inst_a, inst_b;
  logic        ready_a, ready_b, busy_a, busy_b;
  logic [10:0] cnt_a;
  logic [2:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_FLUSH = 2;

  int              m_state = M_IDLE;
  byte unsigned    q[$];
  int              m_wptr = 0;
  int              m_cnt = 0;
  logic [31:0]     mem_a [1024];
  bit              wr_a  [1024];
  logic [31:0]     mem_b [4];
  bit              wr_b  [4];

  inst_mem #(.ADDR_WIDTH(10)) u_dut_a (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_a),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ready_a), .ld_done(ld_done), .busy(busy_a), .word_cnt(cnt_a)
  );

  inst_mem #(.ADDR_WIDTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ready_b), .ld_done(ld_done), .busy(busy_b), .word_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Store the pending bytes as one big-endian word, zero-padded
  task automatic commit();
    logic [31:0] w = '0;
    foreach (q[i]) w[31-8*i -: 8] = q[i];
    mem_a[m_wptr % 1024] = w;
    wr_a[m_wptr % 1024]  = 1'b1;
    mem_b[m_wptr % 4]    = w;
    wr_b[m_wptr % 4]     = 1'b1;
    m_wptr++;
    m_cnt++;
    q.delete();
  endtask

  task automatic model_edge(input bit s, input bit v, input logic [7:0] d, input bit dn);
    if (s) begin
      q.delete();
      m_wptr  = 0;
      m_cnt   = 0;
      m_state = M_LOAD;
    end else if (m_state == M_LOAD) begin
      if (v) begin
        q.push_back(d);
        if (q.size() == 4) commit();
      end
      if (dn) m_state = (q.size() == 0) ? M_IDLE : M_FLUSH;
    end else if (m_state == M_FLUSH) begin
      commit();
      m_state = M_IDLE;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = M_IDLE;
    m_wptr  = 0;
    m_cnt   = 0;
  endtask

  task automatic check_status();
    check("busy_a",  32'(busy_a),  32'(m_state != M_IDLE));
    check("ready_a", 32'(ready_a), 32'(m_state == M_LOAD));
    check("cnt_a",   32'(cnt_a),   32'(min_int(m_cnt, 1024)));
    check("busy_b",  32'(busy_b),  32'(m_state != M_IDLE));
    check("ready_b", 32'(ready_b), 32'(m_state == M_LOAD));
    check("cnt_b",   32'(cnt_b),   32'(min_int(m_cnt, 4)));
  endtask

  // Random fetch with aliased upper/lower address bits
  task automatic probe();
    logic [31:0] r;
    int idx;
    r   = $urandom;
    idx = $urandom_range(0, 7);
    ce   = ($urandom_range(0, 3) != 0);
    addr = {r[31:12], 10'(idx), r[1:0]};
    #1;
    if (!ce || m_state != M_IDLE) begin
      check("inst_a_gated", inst_a, 32'h0);
      check("inst_b_gated", inst_b, 32'h0);
    end else begin
      if (wr_a[idx])     check("inst_a", inst_a, mem_a[idx]);
      if (wr_b[idx % 4]) check("inst_b", inst_b, mem_b[idx % 4]);
    end
  endtask

  task automatic step(input bit s, input bit v, input logic [7:0] d, input bit dn);
    ld_start = s;
    ld_valid = v;
    ld_data  = d;
    ld_done  = dn;
    model_edge(s, v, d, dn);
    @(posedge clk);
    #1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_done  = 1'b0;
    check_status();
    probe();
  endtask

  task automatic fetch(input logic [31:0] a, input logic c);
    addr = a;
    ce   = c;
    #1;
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    model_reset();
    ce   = 1'b1;
    addr = '0;
    #1;
    check("rst_busy",  32'(busy_a),  32'h0);
    check("rst_ready", 32'(ready_a), 32'h0);
    check("rst_cnt",   32'(cnt_a),   32'h0);
    check("rst_inst",  inst_a,       32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] bytes [4];
    #1 rst = 1'b1;
    ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("init_busy",  32'(busy_a),  32'h0);
    check("init_ready", 32'(ready_a), 32'h0);
    check("init_cnt",   32'(cnt_a),   32'h0);
    check("init_inst",  inst_a,       32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Full-word load
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h34, 0);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'hFF, 0);
    check("full_busy_before_done", 32'(busy_a), 32'h1);
    step(0, 0, 8'h00, 1);
    check("full_busy_after_done", 32'(busy_a), 32'h0);
    check("full_cnt", 32'(cnt_a), 32'h1);
    fetch(32'h0, 1'b1);
    check("full_inst", inst_a, 32'h340100FF);

    // Partial flush
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'hAA, 0);
    step(0, 1, 8'hBB, 0);
    step(0, 0, 8'h00, 1);
    check("flush_busy", 32'(busy_a), 32'h1);
    check("flush_ready", 32'(ready_a), 32'h0);
    step(0, 0, 8'h00, 0);
    check("flush_idle", 32'(busy_a), 32'h0);
    check("flush_cnt", 32'(cnt_a), 32'h1);
    fetch(32'h0, 1'b1);
    check("flush_inst", inst_a, 32'hAABB0000);

    // Last byte together with done
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h12, 0);
    step(0, 1, 8'h34, 0);
    step(0, 1, 8'h56, 0);
    step(0, 1, 8'h78, 1);
    check("same_busy", 32'(busy_a), 32'h0);
    check("same_cnt", 32'(cnt_a), 32'h1);
    fetch(32'h0, 1'b1);
    check("same_inst", inst_a, 32'h12345678);

    // Five words: the small instance wraps and saturates
    step(1, 0, 8'h00, 0);
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) step(0, 1, 8'(16 * (w + 1) + b), 0);
    end
    step(0, 0, 8'h00, 1);
    check("wrap_cnt_b", 32'(cnt_b), 32'h4);
    check("wrap_cnt_a", 32'(cnt_a), 32'h5);
    fetch(32'h0, 1'b1);
    check("wrap_inst_b", inst_b, 32'h50515253);
    check("wrap_inst_a", inst_a, 32'h10111213);

    // Fetch gating and aliasing
    fetch(32'h0, 1'b0);
    check("gate_ce", inst_a, 32'h0);
    fetch(32'h1003, 1'b1);
    check("alias_1003", inst_a, 32'h10111213);

    // Reset partway through the second word
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 0);
    step(0, 1, 8'h33, 0);
    step(0, 1, 8'h44, 0);
    step(0, 1, 8'h55, 0);
    fetch(32'h0, 1'b1);
    check("gate_busy", inst_a, 32'h0);
    step(0, 1, 8'h66, 0);
    mid_reset();
    @(posedge clk);
    #1;
    fetch(32'h0, 1'b1);
    check("rst_keep_w0", inst_a, 32'h11223344);
    fetch(32'h4, 1'b1);
    check("rst_keep_w1", inst_a, 32'h20212223);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit s, v, dn;
      if ($urandom_range(0, 399) == 0) begin
        mid_reset();
        continue;
      end
      s  = ($urandom_range(0, 49) == 0);
      v  = ($urandom_range(0, 1) == 1);
      dn = ($urandom_range(0, 19) == 0);
      if (m_state == M_IDLE && $urandom_range(0, 3) == 0) s = 1'b1;
      bytes[0] = 8'($urandom);
      step(s, v, bytes[0], dn);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
